// File: rtl/timer_host_ctrl.sv
// timer_host_ctrl: Avalon-MM initiator for the 16-bit interval timer slave.
// Programs the 64-bit period and control, clears status on each timeout irq,
// counts serviced timeouts and reads back a 64-bit counter snapshot on demand.
// Bus outputs are decoded from the state register, so an asynchronous reset
// returns the bus to idle within the same cycle it is asserted.
module timer_host_ctrl #(
    parameter bit CONTINUOUS = 1'b1,
    parameter int TICK_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [63:0]       cmd_period,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              snap_valid,
    output logic [63:0]       snap_value,
    output logic [3:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              irq_in
);

    typedef enum logic [3:0] {
        IDLE, WR_PER, WR_CTRL, RUN, CLR_STS,
        STOP_CTRL, STOP_STS, SNAP_WR, SNAP_RD, SNAP_DONE
    } state_e;

    // Control register bits: ITO=bit0, CONT=bit1, START=bit2, STOP=bit3
    localparam logic [15:0] CTRL_START = CONTINUOUS ? 16'h0007 : 16'h0005;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    localparam logic [3:0] A_STATUS  = 4'd0;
    localparam logic [3:0] A_CONTROL = 4'd1;
    localparam logic [3:0] A_PERIOD0 = 4'd2;
    localparam logic [3:0] A_SNAP0   = 4'd6;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;          // halfword index within a 4-beat burst
    logic [63:0]         period_q, period_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic [63:0]         snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;
    logic [47:0]         cap_q, cap_d;          // snapshot halfwords 0..2 collected so far
    logic                ret_run_q, ret_run_d;  // snapshot was launched from RUN

    function automatic logic [15:0] period_hw(input logic [63:0] v, input logic [1:0] i);
        case (i)
            2'd0:    period_hw = v[15:0];
            2'd1:    period_hw = v[31:16];
            2'd2:    period_hw = v[47:32];
            default: period_hw = v[63:48];
        endcase
    endfunction

    // State register and datapath flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            period_q     <= '0;
            tick_count_q <= '0;
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
            cap_q        <= '0;
            ret_run_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            period_q     <= period_d;
            tick_count_q <= tick_count_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            cap_q        <= cap_d;
            ret_run_q    <= ret_run_d;
        end
    end

    // Next-state, bus beat decode and datapath updates
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        period_d      = period_q;
        tick_count_d  = tick_count_q;
        snap_value_d  = snap_value_q;
        snap_valid_d  = 1'b0;
        cap_d         = cap_q;
        ret_run_d     = ret_run_q;
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        av_address    = 4'd0;
        av_writedata  = 16'h0000;
        tick          = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    period_d = cmd_period;
                    idx_d    = 2'd0;
                    state_d  = WR_PER;
                end else if (cmd_snap) begin
                    ret_run_d = 1'b0;
                    state_d   = SNAP_WR;
                end
            end
            WR_PER: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_PERIOD0 + {2'b00, idx_q};
                av_writedata  = period_hw(period_q, idx_q);
                idx_d         = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = WR_CTRL;
            end
            WR_CTRL: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_CONTROL;
                av_writedata  = CTRL_START;
                state_d       = RUN;
            end
            RUN: begin
                if (cmd_stop) begin
                    state_d = STOP_CTRL;
                end else if (irq_in) begin
                    state_d = CLR_STS;
                end else if (cmd_snap) begin
                    ret_run_d = 1'b1;
                    state_d   = SNAP_WR;
                end
            end
            CLR_STS: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_STATUS;
                tick          = 1'b1;
                tick_count_d  = tick_count_q + TICK_W'(1);
                state_d       = CONTINUOUS ? RUN : IDLE;
            end
            STOP_CTRL: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_CONTROL;
                av_writedata  = CTRL_STOP;
                state_d       = STOP_STS;
            end
            STOP_STS: begin
                // Discards any timeout still pending in the slave
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_STATUS;
                state_d       = IDLE;
            end
            SNAP_WR: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = A_SNAP0;
                idx_d         = 2'd0;
                state_d       = SNAP_RD;
            end
            SNAP_RD: begin
                // Reads are pipelined: data for the previous beat arrives this cycle
                av_chipselect = 1'b1;
                av_address    = A_SNAP0 + {2'b00, idx_q};
                case (idx_q)
                    2'd1:    cap_d[15:0]  = av_readdata;
                    2'd2:    cap_d[31:16] = av_readdata;
                    2'd3:    cap_d[47:32] = av_readdata;
                    default: ;
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = SNAP_DONE;
            end
            SNAP_DONE: begin
                snap_value_d = {av_readdata, cap_q};
                snap_valid_d = 1'b1;
                state_d      = ret_run_q ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE) && (state_q != RUN);
    assign running    = (state_q == RUN);
    assign tick_count = tick_count_q;
    assign snap_valid = snap_valid_q;
    assign snap_value = snap_value_q;

endmodule

// File: tb/tb_timer_host_ctrl.sv
// tb_timer_host_ctrl: directed bench for timer_host_ctrl with a behavioural
// interval-timer slave per DUT. Instance 0 is continuous, instance 1 one-shot.
module tb_timer_host_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start [2];
    logic [63:0] cmd_period [2];
    logic        cmd_stop [2];
    logic        cmd_snap [2];
    logic        busy [2];
    logic        running [2];
    logic        tick [2];
    logic [31:0] tick_count [2];
    logic        snap_valid [2];
    logic [63:0] snap_value [2];
    logic [3:0]  av_addr [2];
    logic        av_cs [2];
    logic        av_wn [2];
    logic [15:0] av_wd [2];
    logic [15:0] av_rd [2];
    logic        irq [2];

    // slave model state
    logic        s_to [2];
    logic        s_ito [2];
    logic        s_cont [2];
    logic        s_run [2];
    logic [63:0] s_per [2];
    logic [63:0] s_cnt [2];
    logic [63:0] s_snap [2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int sel = 0;

    logic [19:0] wr_log [$];
    int          wr_cyc [$];
    int          rd_addr [$];
    int          rd_cyc [$];
    int          tick_cyc [$];
    logic [31:0] tick_cnt [$];
    int          snapv_cyc [$];
    logic        snapv_run [$];
    logic        prev_tick = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_host_ctrl #(.CONTINUOUS(1'b1), .TICK_W(32)) u_cont (
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start[0]), .cmd_period(cmd_period[0]),
        .cmd_stop(cmd_stop[0]), .cmd_snap(cmd_snap[0]),
        .busy(busy[0]), .running(running[0]), .tick(tick[0]),
        .tick_count(tick_count[0]), .snap_valid(snap_valid[0]), .snap_value(snap_value[0]),
        .av_address(av_addr[0]), .av_chipselect(av_cs[0]), .av_write_n(av_wn[0]),
        .av_writedata(av_wd[0]), .av_readdata(av_rd[0]), .irq_in(irq[0])
    );

    timer_host_ctrl #(.CONTINUOUS(1'b0), .TICK_W(32)) u_once (
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start[1]), .cmd_period(cmd_period[1]),
        .cmd_stop(cmd_stop[1]), .cmd_snap(cmd_snap[1]),
        .busy(busy[1]), .running(running[1]), .tick(tick[1]),
        .tick_count(tick_count[1]), .snap_valid(snap_valid[1]), .snap_value(snap_value[1]),
        .av_address(av_addr[1]), .av_chipselect(av_cs[1]), .av_write_n(av_wn[1]),
        .av_writedata(av_wd[1]), .av_readdata(av_rd[1]), .irq_in(irq[1])
    );

    // Interval timer slave: counts down from period, timeout every period+1 clks
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                s_to[k] <= 1'b0; s_ito[k] <= 1'b0; s_cont[k] <= 1'b0; s_run[k] <= 1'b0;
                s_per[k] <= '0; s_cnt[k] <= '0; s_snap[k] <= '0; av_rd[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (s_run[k]) begin
                    if (s_cnt[k] == 64'd0) begin
                        s_to[k]  <= 1'b1;
                        s_cnt[k] <= s_per[k];
                        if (!s_cont[k]) s_run[k] <= 1'b0;
                    end else begin
                        s_cnt[k] <= s_cnt[k] - 64'd1;
                    end
                end
                if (av_cs[k] && !av_wn[k]) begin
                    case (av_addr[k])
                        4'd0: s_to[k] <= 1'b0;
                        4'd1: begin
                            s_ito[k]  <= av_wd[k][0];
                            s_cont[k] <= av_wd[k][1];
                            if (av_wd[k][2]) begin s_run[k] <= 1'b1; s_cnt[k] <= s_per[k]; end
                            if (av_wd[k][3]) s_run[k] <= 1'b0;
                        end
                        4'd2: s_per[k][15:0]  <= av_wd[k];
                        4'd3: s_per[k][31:16] <= av_wd[k];
                        4'd4: s_per[k][47:32] <= av_wd[k];
                        4'd5: s_per[k][63:48] <= av_wd[k];
                        4'd6: s_snap[k] <= s_cnt[k];
                        default: ;
                    endcase
                end
                if (av_cs[k] && av_wn[k]) begin
                    case (av_addr[k])
                        4'd0: av_rd[k] <= {15'd0, s_to[k]};
                        4'd1: av_rd[k] <= {14'd0, s_cont[k], s_ito[k]};
                        4'd6: av_rd[k] <= s_snap[k][15:0];
                        4'd7: av_rd[k] <= s_snap[k][31:16];
                        4'd8: av_rd[k] <= s_snap[k][47:32];
                        4'd9: av_rd[k] <= s_snap[k][63:48];
                        default: av_rd[k] <= 16'h0000;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) irq[k] = s_to[k] & s_ito[k];
    end

    // Bus / event monitor for the selected instance
    always @(negedge clk) begin
        if (av_cs[sel] && !av_wn[sel]) begin
            wr_log.push_back({av_addr[sel], av_wd[sel]});
            wr_cyc.push_back(cyc);
        end
        if (av_cs[sel] && av_wn[sel]) begin
            rd_addr.push_back(int'(av_addr[sel]));
            rd_cyc.push_back(cyc);
        end
        if (tick[sel]) tick_cyc.push_back(cyc);
        if (prev_tick) tick_cnt.push_back(tick_count[sel]);
        if (snap_valid[sel]) begin
            snapv_cyc.push_back(cyc);
            snapv_run.push_back(running[sel]);
        end
        prev_tick <= tick[sel];
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_logs();
        wr_log.delete(); wr_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
        tick_cyc.delete(); tick_cnt.delete(); snapv_cyc.delete(); snapv_run.delete();
    endtask

    task automatic pulse_start(input int k, input logic [63:0] p);
        cmd_period[k] = p;
        cmd_start[k]  = 1'b1;
        step();
        cmd_start[k]  = 1'b0;
    endtask

    task automatic do_stop(input int k);
        cmd_stop[k] = 1'b1;
        step();
        cmd_stop[k] = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        step(); step();
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (av_cs[k] !== 1'b0 || av_wn[k] !== 1'b1 || av_addr[k] !== 4'd0 || av_wd[k] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_bus[%0d]: got cs=%b wn=%b addr=%0h wd=%0h, expected 0 1 0 0",
                         k, av_cs[k], av_wn[k], av_addr[k], av_wd[k]);
            end
            n_chk++;
            if (busy[k] !== 1'b0 || running[k] !== 1'b0 || tick[k] !== 1'b0 || snap_valid[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got busy=%b run=%b tick=%b sv=%b, expected all 0",
                         k, busy[k], running[k], tick[k], snap_valid[k]);
            end
            n_chk++;
            if (tick_count[k] !== 32'd0 || snap_value[k] !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_regs[%0d]: got tc=%0h snap=%0h, expected 0 0", k, tick_count[k], snap_value[k]);
            end
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_continuous();
        int c, n;
        logic [19:0] ew [5];
        ew = '{20'h2_0009, 20'h3_0000, 20'h4_0000, 20'h5_0000, 20'h1_0007};
        sel = 0;
        clr_logs();
        c = cyc;
        pulse_start(0, 64'd9);
        n_chk++;
        if (busy[0] !== 1'b1 || running[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_busy: got busy=%b running=%b, expected 1 0", busy[0], running[0]);
        end
        n = 0;
        while (tick_cnt.size() < 3 && n < 200) begin step(); n++; end
        n_chk++;
        if (tick_cnt.size() < 3) begin
            n_fail++;
            $display("FAIL cont_timeout: got %0d ticks, expected 3 within 200 clks", tick_cnt.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++;
                if (wr_log[i] !== ew[i] || wr_cyc[i] !== c + 1 + i) begin
                    n_fail++;
                    $display("FAIL cont_wr%0d: got %05h@%0d, expected %05h@%0d", i, wr_log[i], wr_cyc[i], ew[i], c + 1 + i);
                end
            end
            n_chk++;
            if (tick_cyc[0] !== c + 17) begin
                n_fail++;
                $display("FAIL cont_first_tick: got cycle %0d, expected %0d", tick_cyc[0], c + 17);
            end
            n_chk++;
            if (tick_cyc[1] - tick_cyc[0] !== 10 || tick_cyc[2] - tick_cyc[1] !== 10) begin
                n_fail++;
                $display("FAIL cont_interval: got %0d %0d, expected 10 10",
                         tick_cyc[1] - tick_cyc[0], tick_cyc[2] - tick_cyc[1]);
            end
            n_chk++;
            if (wr_log[5] !== 20'h0_0000 || wr_cyc[5] !== tick_cyc[0]) begin
                n_fail++;
                $display("FAIL cont_clr: got %05h@%0d, expected 00000@%0d", wr_log[5], wr_cyc[5], tick_cyc[0]);
            end
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (tick_cnt[i] !== 32'(i + 1)) begin
                    n_fail++;
                    $display("FAIL cont_count%0d: got %0d, expected %0d", i, tick_cnt[i], i + 1);
                end
            end
        end
        n_chk++;
        if (running[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_running: got %b, expected 1", running[0]);
        end
    endtask

    task automatic test_stop();
        int n;
        sel = 0;
        n = 0;
        while (!(running[0] && !irq[0]) && n < 50) begin step(); n++; end
        clr_logs();
        cmd_stop[0] = 1'b1;
        step();
        cmd_stop[0] = 1'b0;
        repeat (100) step();
        n_chk++;
        if (wr_log.size() !== 2 || wr_log[0] !== 20'h1_0008 || wr_log[1] !== 20'h0_0000 || wr_cyc[1] !== wr_cyc[0] + 1) begin
            n_fail++;
            $display("FAIL stop_writes: got n=%0d %05h %05h, expected 2 10008 00000", wr_log.size(), wr_log[0], wr_log[1]);
        end
        n_chk++;
        if (tick_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL stop_ticks: got %0d ticks, expected 0", tick_cyc.size());
        end
        n_chk++;
        if (running[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_state: got running=%b busy=%b, expected 0 0", running[0], busy[0]);
        end
    endtask

    task automatic test_snap();
        logic [63:0] ps [2];
        logic [63:0] exp_snap;
        int c, n, w, s;
        ps = '{64'h0000_0000_0000_FFFF, 64'h0001_0002_0003_FFFF};
        sel = 0;
        for (int p = 0; p < 2; p++) begin
            clr_logs();
            pulse_start(0, ps[p]);
            n = 0;
            while (!running[0] && n < 20) begin step(); n++; end
            w = cyc - 1;
            repeat (5) step();
            clr_logs();
            c = cyc;
            cmd_snap[0] = 1'b1;
            step();
            cmd_snap[0] = 1'b0;
            n = 0;
            while (snapv_cyc.size() == 0 && n < 30) begin step(); n++; end
            n_chk++;
            if (snapv_cyc.size() == 0) begin
                n_fail++;
                $display("FAIL snap%0d_timeout: got no snap_valid, expected one within 30 clks", p);
            end else begin
                s = wr_cyc[0];
                n_chk++;
                if (wr_log.size() !== 1 || wr_log[0] !== 20'h6_0000 || s !== c + 1) begin
                    n_fail++;
                    $display("FAIL snap%0d_wr: got n=%0d %05h@%0d, expected 1 60000@%0d", p, wr_log.size(), wr_log[0], s, c + 1);
                end
                n_chk++;
                if (rd_addr.size() !== 4) begin
                    n_fail++;
                    $display("FAIL snap%0d_nrd: got %0d reads, expected 4", p, rd_addr.size());
                end
                for (int i = 0; i < 4; i++) begin
                    n_chk++;
                    if (rd_addr[i] !== 6 + i || rd_cyc[i] !== s + 1 + i) begin
                        n_fail++;
                        $display("FAIL snap%0d_rd%0d: got a%0d@%0d, expected a%0d@%0d", p, i, rd_addr[i], rd_cyc[i], 6 + i, s + 1 + i);
                    end
                end
                n_chk++;
                if (snapv_cyc[0] !== s + 6 || snapv_run[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL snap%0d_valid: got @%0d run=%b, expected @%0d run=1", p, snapv_cyc[0], snapv_run[0], s + 6);
                end
                exp_snap = ps[p] + 64'd1 - 64'(s - w);
                n_chk++;
                if (snap_value[0] !== exp_snap) begin
                    n_fail++;
                    $display("FAIL snap%0d_value: got %016h, expected %016h", p, snap_value[0], exp_snap);
                end
            end
            do_stop(0);
        end
    endtask

    task automatic test_oneshot();
        int c;
        sel = 1;
        clr_logs();
        c = cyc;
        pulse_start(1, 64'd4);
        repeat (59) step();
        n_chk++;
        if (wr_log.size() !== 6 || wr_log[4] !== 20'h1_0005 || wr_log[5] !== 20'h0_0000) begin
            n_fail++;
            $display("FAIL once_writes: got n=%0d ctrl=%05h last=%05h, expected 6 10005 00000", wr_log.size(), wr_log[4], wr_log[5]);
        end
        n_chk++;
        if (tick_cyc.size() !== 1 || tick_cyc[0] !== c + 12) begin
            n_fail++;
            $display("FAIL once_tick: got n=%0d @%0d, expected 1 @%0d", tick_cyc.size(), tick_cyc[0], c + 12);
        end
        n_chk++;
        if (tick_count[1] !== 32'd1 || running[1] !== 1'b0 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL once_end: got tc=%0d run=%b busy=%b, expected 1 0 0", tick_count[1], running[1], busy[1]);
        end
    endtask

    task automatic test_stop_irq();
        int n;
        sel = 0;
        pulse_start(0, 64'd9);
        n = 0;
        while (!(irq[0] && running[0]) && n < 40) begin step(); n++; end
        n_chk++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL stopirq_wait: got no irq in RUN, expected one within 40 clks");
        end
        clr_logs();
        cmd_stop[0] = 1'b1;
        step();
        cmd_stop[0] = 1'b0;
        repeat (30) step();
        n_chk++;
        if (tick_cyc.size() !== 0 || tick_count[0] !== 32'd3) begin
            n_fail++;
            $display("FAIL stopirq_tick: got %0d ticks tc=%0d, expected 0 ticks tc=3", tick_cyc.size(), tick_count[0]);
        end
        n_chk++;
        if (wr_log.size() !== 2 || wr_log[0] !== 20'h1_0008 || wr_log[1] !== 20'h0_0000) begin
            n_fail++;
            $display("FAIL stopirq_writes: got n=%0d %05h %05h, expected 2 10008 00000", wr_log.size(), wr_log[0], wr_log[1]);
        end
        n_chk++;
        if (irq[0] !== 1'b0 || running[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stopirq_state: got irq=%b run=%b busy=%b, expected 0 0 0", irq[0], running[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        n_chk++;
        if (tick_count[0] !== 32'd3) begin
            n_fail++;
            $display("FAIL rstmid_pre: got tc=%0d, expected 3", tick_count[0]);
        end
        pulse_start(0, 64'd9);
        step();
        n_chk++;
        if (av_cs[0] !== 1'b1 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_inseq: got cs=%b busy=%b, expected 1 1", av_cs[0], busy[0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (av_cs[0] !== 1'b0 || av_wn[0] !== 1'b1 || av_addr[0] !== 4'd0 || av_wd[0] !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_bus: got cs=%b wn=%b addr=%0h wd=%0h, expected 0 1 0 0", av_cs[0], av_wn[0], av_addr[0], av_wd[0]);
        end
        n_chk++;
        if (busy[0] !== 1'b0 || running[0] !== 1'b0 || tick_count[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_regs: got busy=%b run=%b tc=%0d, expected 0 0 0", busy[0], running[0], tick_count[0]);
        end
        step();
        reset_n = 1'b1;
        step(); step();
        n_chk++;
        if (av_cs[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: got cs=%b busy=%b, expected 0 0", av_cs[0], busy[0]);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmd_start[k] = 1'b0; cmd_period[k] = '0; cmd_stop[k] = 1'b0; cmd_snap[k] = 1'b0;
        end
        test_reset();
        test_continuous();
        test_stop();
        test_snap();
        test_oneshot();
        test_stop_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
